dma_engine: RTL and testbench

//  Multi-channel DMA master for the MMU. Channel 0 is the OAM DMA (FF46): 160 bytes, {src,00}->FE00.

---
 rtl/dma_engine_if.sv | 24 ++
 rtl/dma_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_dma_engine.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_engine_if.sv
// Bus bundle for dma_engine: the CPU register port and the DMA memory port.
// The master modport is the DMA engine's view; the slave modport is the MMU/CPU side.
interface dma_engine_if;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_write_en;
  logic        reg_read_en;
  logic [7:0]  reg_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_read_en;
  logic        mem_write_en;

  modport master (
    input  reg_addr, reg_wdata, reg_write_en, reg_read_en, mem_rdata,
    output reg_rdata, mem_addr, mem_wdata, mem_read_en, mem_write_en
  );

  modport slave (
    output reg_addr, reg_wdata, reg_write_en, reg_read_en, mem_rdata,
    input  reg_rdata, mem_addr, mem_wdata, mem_read_en, mem_write_en
  );
endinterface

// File: rtl/dma_engine.sv
// OAM DMA (FF46) plus, when DMA_HDMA_EN is defined, CGB VRAM HDMA (FF51-FF55, GDMA and HBlank).
// Every byte takes four cycles (read, write, hold, advance); OAM wins arbitration at byte boundaries.
module dma_engine #(
  parameter int         OAM_LEN       = 160,
  parameter int         HDMA_BLOCK    = 16,
  parameter logic [7:0] OPEN_BUS_DATA = 8'hFF
) (
  input  logic         clk,
  input  logic         reset,
  dma_engine_if.master bus,
  output logic         active,
  output logic         cpu_halt,
  input  logic         hblank_start,
  input  logic         lcd_on
);
  typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_P4} phase_t;
  typedef enum logic {CH_OAM, CH_HDMA} chan_t;

  localparam logic [7:0] OAM_LAST = 8'(OAM_LEN - 1);
  localparam logic [3:0] BLK_LAST = 4'(HDMA_BLOCK - 1);

  phase_t      state, state_d;
  chan_t       ch, ch_d;
  logic [7:0]  wdata_q;
  logic        boundary;
  logic        hdma_req_d, hdma_pend;
  logic [15:0] hdma_src_addr, hdma_dst_addr;
  logic [7:0]  ff55_rdata;

  assign boundary = (state == S_IDLE) || (state == S_P4);

  logic       oam_wr, oam_busy, oam_busy_d, oam_rst, oam_rst_d;
  logic [7:0] oam_reg, oam_hi, oam_hi_d, oam_idx, oam_idx_d;
  logic [7:0] oam_rst_hi, oam_rst_hi_d, oam_hi_new;

  assign oam_wr     = bus.reg_write_en && (bus.reg_addr == 16'hFF46);
  assign oam_hi_new = (bus.reg_wdata < 8'hE0) ? bus.reg_wdata : bus.reg_wdata - 8'h20;

  // A write landing mid-byte is parked in oam_rst and applied at the next byte boundary.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    oam_busy_d   = oam_busy;
    oam_idx_d    = oam_idx;
    oam_hi_d     = oam_hi;
    oam_rst_d    = oam_rst;
    oam_rst_hi_d = oam_rst_hi;
    if (state == S_P4 && ch == CH_OAM) begin
      if (oam_idx == OAM_LAST) begin
        oam_busy_d = 1'b0;
        oam_idx_d  = 8'd0;
      end else begin
        oam_idx_d = oam_idx + 8'd1;
      end
    end
    if (boundary && oam_rst) begin
      oam_busy_d = 1'b1;
      oam_idx_d  = 8'd0;
      oam_hi_d   = oam_rst_hi;
      oam_rst_d  = 1'b0;
    end
    if (oam_wr) begin
      if (boundary) begin
        oam_busy_d = 1'b1;
        oam_idx_d  = 8'd0;
        oam_hi_d   = oam_hi_new;
        oam_rst_d  = 1'b0;
      end else begin
        oam_rst_d    = 1'b1;
        oam_rst_hi_d = oam_hi_new;
      end
    end
  end

`ifdef DMA_HDMA_EN
  typedef enum logic [1:0] {HM_IDLE, HM_GDMA, HM_HBL} hmode_t;

  hmode_t      mode, mode_d;
  logic [15:0] src, src_d;
  logic [12:0] dst, dst_d;
  logic [6:0]  len, len_d;
  logic [3:0]  cnt, cnt_d;
  logic        blk, blk_d, cancel, cancel_d;
  logic [7:0]  idle_rd, idle_rd_d;
  logic        byte_done, wr51, wr52, wr53, wr54, wr55;

  assign byte_done = (state == S_P4) && (ch == CH_HDMA);
  assign wr51 = bus.reg_write_en && (bus.reg_addr == 16'hFF51);
  assign wr52 = bus.reg_write_en && (bus.reg_addr == 16'hFF52);
  assign wr53 = bus.reg_write_en && (bus.reg_addr == 16'hFF53);
  assign wr54 = bus.reg_write_en && (bus.reg_addr == 16'hFF54);
  assign wr55 = bus.reg_write_en && (bus.reg_addr == 16'hFF55);

  // len holds blocks remaining minus one; blk marks a block in progress or waiting for the bus.
  always_comb begin
    mode_d = mode;  src_d = src;  dst_d = dst;  len_d = len;  cnt_d = cnt;
    blk_d = blk;  cancel_d = cancel;  idle_rd_d = idle_rd;
    if (wr51) src_d[15:8] = bus.reg_wdata;
    if (wr52) src_d[7:0]  = {bus.reg_wdata[7:4], 4'h0};
    if (wr53) dst_d[12:8] = bus.reg_wdata[4:0];
    if (wr54) dst_d[7:0]  = {bus.reg_wdata[7:4], 4'h0};
    if (byte_done) begin
      src_d = src + 16'd1;
      dst_d = dst + 13'd1;
      cnt_d = cnt + 4'd1;
      if (dst == 13'h1FFF || (cnt == BLK_LAST && len == 7'd0)) begin
        mode_d = HM_IDLE;  blk_d = 1'b0;  cancel_d = 1'b0;  cnt_d = 4'd0;  idle_rd_d = 8'hFF;
      end else if (cnt == BLK_LAST) begin
        len_d = len - 7'd1;
        if (mode == HM_HBL) begin
          blk_d = 1'b0;
          if (cancel) begin
            mode_d = HM_IDLE;  cancel_d = 1'b0;  idle_rd_d = {1'b1, len - 7'd1};
          end
        end
      end
    end
    if (mode == HM_HBL && hblank_start && lcd_on && !blk) blk_d = 1'b1;
    if (wr55) begin
      case (mode)
        HM_IDLE: begin
          len_d = bus.reg_wdata[6:0];
          cnt_d = 4'd0;
          if (bus.reg_wdata[7]) mode_d = HM_HBL;
          else begin
            mode_d = HM_GDMA;
            blk_d  = 1'b1;
          end
        end
        HM_HBL: begin
          if (bus.reg_wdata[7]) begin
            len_d    = bus.reg_wdata[6:0];
            cancel_d = 1'b0;
          end else if (blk_d) begin
            cancel_d = 1'b1;
          end else begin
            mode_d    = HM_IDLE;
            idle_rd_d = {1'b1, len_d};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode <= HM_IDLE;  src <= '0;  dst <= '0;  len <= '0;  cnt <= '0;
      blk <= 1'b0;  cancel <= 1'b0;  idle_rd <= 8'hFF;
    end else begin
      mode <= mode_d;  src <= src_d;  dst <= dst_d;  len <= len_d;  cnt <= cnt_d;
      blk <= blk_d;  cancel <= cancel_d;  idle_rd <= idle_rd_d;
    end
  end

  assign hdma_req_d    = blk_d;
  assign hdma_pend     = blk;
  assign hdma_src_addr = src;
  assign hdma_dst_addr = {3'b100, dst};
  assign ff55_rdata    = (mode != HM_IDLE) ? {1'b0, len} : idle_rd;
  assign cpu_halt      = (mode == HM_GDMA);
`else
  logic unused_hdma;
  assign unused_hdma   = &{1'b0, hblank_start, lcd_on, BLK_LAST};
  assign hdma_req_d    = 1'b0;
  assign hdma_pend     = 1'b0;
  assign hdma_src_addr = 16'h0000;
  assign hdma_dst_addr = 16'h0000;
  assign ff55_rdata    = OPEN_BUS_DATA;
  assign cpu_halt      = 1'b0;
`endif

  always_comb begin
    state_d = state;
    ch_d    = ch;
    case (state)
      S_IDLE, S_P4: begin
        if (oam_busy_d) begin
          state_d = S_P1;  ch_d = CH_OAM;
        end else if (hdma_req_d) begin
          state_d = S_P1;  ch_d = CH_HDMA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_P1:    state_d = S_P2;
      S_P2:    state_d = S_P3;
      S_P3:    state_d = S_P4;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state <= S_IDLE;  ch <= CH_OAM;  wdata_q <= 8'h00;
      oam_reg <= 8'h00;  oam_hi <= 8'h00;  oam_idx <= 8'h00;  oam_busy <= 1'b0;
      oam_rst <= 1'b0;  oam_rst_hi <= 8'h00;
    end else begin
      state <= state_d;  ch <= ch_d;
      oam_hi <= oam_hi_d;  oam_idx <= oam_idx_d;  oam_busy <= oam_busy_d;
      oam_rst <= oam_rst_d;  oam_rst_hi <= oam_rst_hi_d;
      if (oam_wr) oam_reg <= bus.reg_wdata;
      if (state == S_P2) wdata_q <= bus.mem_rdata;
    end
  end

  // Read data arrives during P2, so it is passed straight through that cycle and held for P3.
  always_comb begin
    logic [15:0] src_a, dst_a;
    src_a = (ch == CH_OAM) ? {oam_hi, oam_idx} : hdma_src_addr;
    dst_a = (ch == CH_OAM) ? {8'hFE, oam_idx}  : hdma_dst_addr;
    bus.mem_addr     = 16'h0000;
    bus.mem_wdata    = wdata_q;
    bus.mem_read_en  = 1'b0;
    bus.mem_write_en = 1'b0;
    case (state)
      S_P1: begin bus.mem_addr = src_a; bus.mem_read_en = 1'b1; end
      S_P2: begin bus.mem_addr = dst_a; bus.mem_write_en = 1'b1; bus.mem_wdata = bus.mem_rdata; end
      S_P3: begin bus.mem_addr = dst_a; bus.mem_write_en = 1'b1; end
      S_P4: bus.mem_addr = dst_a;
      default: ;
    endcase
    if (reset) begin
      bus.mem_read_en  = 1'b0;
      bus.mem_write_en = 1'b0;
    end
  end

  always_comb begin
    bus.reg_rdata = OPEN_BUS_DATA;
    if (bus.reg_read_en) begin
      if (bus.reg_addr == 16'hFF46)      bus.reg_rdata = oam_reg;
      else if (bus.reg_addr == 16'hFF55) bus.reg_rdata = ff55_rdata;
    end
  end

  assign active = (state != S_IDLE) || oam_busy || oam_rst || hdma_pend;
endmodule

// File: tb/tb_dma_engine.sv
// Scoreboard bench for dma_engine: every expected byte move is queued as {src,dst} before the
// transfer starts and popped when the DUT begins each write. HDMA scenarios need DMA_HDMA_EN.
module tb_dma_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic active, cpu_halt;
  logic hblank_start = 1'b0;
  logic lcd_on = 1'b1;

  dma_engine_if bus ();

  dma_engine dut (
    .clk(clk), .reset(reset), .bus(bus), .active(active), .cpu_halt(cpu_halt),
    .hblank_start(hblank_start), .lcd_on(lcd_on)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dst;
  } xfer_t;

  xfer_t       exp_q[$];
  xfer_t       exp_e;
  int          total = 0;
  int          bad = 0;
  int          wr_count = 0;
  logic        we_last = 1'b0;
  logic        re_last = 1'b0;
  logic [15:0] rd_addr = 16'h0000;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Memory responder and write monitor, both on the falling edge.
  always @(negedge clk) begin
    if (bus.mem_read_en) begin
      bus.mem_rdata = pat(bus.mem_addr);
      if (!re_last) rd_addr = bus.mem_addr;
    end
    re_last = bus.mem_read_en;
    if (bus.mem_write_en && !we_last) begin
      wr_count++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h", bus.mem_addr, bus.mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({rd_addr, bus.mem_addr, bus.mem_wdata} !== {exp_e.src, exp_e.dst, pat(exp_e.src)}) begin
          bad++;
          $display("FAIL xfer src got=%h want=%h dst got=%h want=%h data got=%h want=%h",
                   rd_addr, exp_e.src, bus.mem_addr, exp_e.dst, bus.mem_wdata, pat(exp_e.src));
        end
      end
    end
    we_last = bus.mem_write_en;
  end

  task automatic push_run(input logic [15:0] src, input logic [15:0] dst, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({src + 16'(i), dst + 16'(i)});
  endtask

  task automatic reg_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.reg_addr = a;  bus.reg_wdata = d;  bus.reg_write_en = 1'b1;
    @(negedge clk);
    bus.reg_write_en = 1'b0;
  endtask

  task automatic reg_rd(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.reg_addr = a;  bus.reg_read_en = 1'b1;
    #1 d = bus.reg_rdata;
    bus.reg_read_en = 1'b0;
  endtask

  task automatic pulse();
    @(negedge clk);
    hblank_start = 1'b1;
    @(negedge clk);
    hblank_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget, output int n);
    n = 0;
    while (active && n < budget) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (active) begin
      bad++;
      $display("FAIL %s_timeout active got=1 want=0 after %0d cycles", name, n);
    end
  endtask

  task automatic check_drained(input string name);
    repeat (40) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drained pending got=%0d want=0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_ff55(input string name, input logic [7:0] want);
    logic [7:0] rd;
    reg_rd(16'hFF55, rd);
    total++;
    if (rd !== want) begin
      bad++;
      $display("FAIL %s_ff55 got=%h want=%h", name, rd, want);
    end
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_read_en, bus.mem_write_en, active, cpu_halt} !== 28'h0) begin
      bad++;
      $display("FAIL reset_outputs addr=%h wdata=%h re=%b we=%b active=%b halt=%b want all 0",
               bus.mem_addr, bus.mem_wdata, bus.mem_read_en, bus.mem_write_en, active, cpu_halt);
    end
    reset = 1'b0;
    @(negedge clk);
    reg_rd(16'hFF46, rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL reset_ff46 got=%h want=00", rd); end
    check_ff55("reset", 8'hFF);
  endtask

  task automatic test_open_bus();
    logic [7:0] rd;
    int base;
    for (int i = 0; i < 5; i++) begin
      reg_rd(16'hFF51 + 16'(i), rd);
      total++;
      if (rd !== 8'hFF) begin bad++; $display("FAIL open_bus_ff5%0d got=%h want=ff", i + 1, rd); end
    end
    reg_rd(16'hFF47, rd);
    total++;
    if (rd !== 8'hFF) begin bad++; $display("FAIL open_bus_ff47 got=%h want=ff", rd); end
`ifndef DMA_HDMA_EN
    base = wr_count;
    reg_wr(16'hFF51, 8'hD0);
    reg_wr(16'hFF55, 8'h00);
    repeat (10) @(negedge clk);
    total++;
    if ({active, cpu_halt} !== 2'b00 || wr_count != base) begin
      bad++;
      $display("FAIL hdma_absent active=%b halt=%b writes=%0d want 0 0 0", active, cpu_halt, wr_count - base);
    end
    check_ff55("hdma_absent", 8'hFF);
`else
    base = 0;
`endif
  endtask

  task automatic test_oam_basic();
    int n;
    push_run(16'hC100, 16'hFE00, 160);
    reg_wr(16'hFF46, 8'hC1);
    wait_idle("oam_basic", 2000, n);
    total++;
    if (n != 640) begin bad++; $display("FAIL oam_basic_cycles got=%0d want=640", n); end
    check_drained("oam_basic");
  endtask

  task automatic test_oam_restart();
    logic [7:0] rd;
    int n, base;
    base = wr_count;
    push_run(16'hC200, 16'hFE00, 160);
    reg_wr(16'hFF46, 8'hE2);
    reg_rd(16'hFF46, rd);
    total++;
    if (rd !== 8'hE2) begin bad++; $display("FAIL oam_readback got=%h want=e2", rd); end
    n = 0;
    while (wr_count - base < 50 && n < 1000) begin
      n++;
      @(posedge clk);
    end
    total++;
    if (wr_count - base != 50) begin
      bad++;
      $display("FAIL oam_restart_reach got=%0d want=50 bytes", wr_count - base);
    end
    exp_q.delete();
    push_run(16'hC300, 16'hFE00, 160);
    reg_wr(16'hFF46, 8'hC3);
    wait_idle("oam_restart", 2000, n);
    check_drained("oam_restart");
    reg_rd(16'hFF46, rd);
    total++;
    if (rd !== 8'hC3) begin bad++; $display("FAIL oam_restart_ff46 got=%h want=c3", rd); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] rd;
    int n;
    push_run(16'hC500, 16'hFE00, 160);
    reg_wr(16'hFF46, 8'hC5);
    n = 0;
    while (!bus.mem_write_en && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    total++;
    if (n >= 20 || bus.mem_write_en !== 1'b0) begin
      bad++;
      $display("FAIL abort_write_en got=%b want=0 (waited %0d)", bus.mem_write_en, n);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({active, bus.mem_read_en, bus.mem_write_en} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle active=%b re=%b we=%b want 0 0 0", active, bus.mem_read_en, bus.mem_write_en);
    end
    reg_rd(16'hFF46, rd);
    total++;
    if (rd !== 8'h00) begin bad++; $display("FAIL abort_ff46 got=%h want=00", rd); end
  endtask

`ifdef DMA_HDMA_EN
  task automatic set_hdma(input logic [7:0] s_hi, input logic [7:0] s_lo,
                          input logic [7:0] d_hi, input logic [7:0] d_lo);
    reg_wr(16'hFF51, s_hi);
    reg_wr(16'hFF52, s_lo);
    reg_wr(16'hFF53, d_hi);
    reg_wr(16'hFF54, d_lo);
  endtask

  task automatic test_gdma();
    int n;
    set_hdma(8'hD0, 8'h05, 8'h01, 8'h20);
    push_run(16'hD000, 16'h8120, 32);
    reg_wr(16'hFF55, 8'h01);
    n = 0;
    while (cpu_halt && n < 500) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 128) begin bad++; $display("FAIL gdma_halt_cycles got=%0d want=128", n); end
    check_drained("gdma");
    check_ff55("gdma_done", 8'hFF);
  endtask

  task automatic test_hblank();
    int n, base;
    set_hdma(8'hC4, 8'h00, 8'h00, 8'h00);
    reg_wr(16'hFF55, 8'h82);
    check_ff55("hbl_armed", 8'h02);
    push_run(16'hC400, 16'h8000, 16);
    pulse();
    wait_idle("hbl_block1", 300, n);
    total++;
    if (n != 64) begin bad++; $display("FAIL hbl_block_cycles got=%0d want=64", n); end
    check_drained("hbl_block1");
    check_ff55("hbl_after1", 8'h01);
    base = wr_count;
    lcd_on = 1'b0;
    pulse();
    repeat (20) @(negedge clk);
    total++;
    if (active !== 1'b0 || wr_count != base) begin
      bad++;
      $display("FAIL hbl_lcd_off active=%b writes=%0d want 0 0", active, wr_count - base);
    end
    lcd_on = 1'b1;
    push_run(16'hC410, 16'h8010, 16);
    pulse();
    repeat (8) @(negedge clk);
    pulse();
    wait_idle("hbl_block2", 300, n);
    check_drained("hbl_block2");
    check_ff55("hbl_after2", 8'h00);
    push_run(16'hC420, 16'h8020, 16);
    pulse();
    wait_idle("hbl_block3", 300, n);
    check_drained("hbl_block3");
    check_ff55("hbl_done", 8'hFF);
  endtask

  task automatic test_cancel();
    int n, base;
    set_hdma(8'hC6, 8'h00, 8'h02, 8'h00);
    reg_wr(16'hFF55, 8'h83);
    push_run(16'hC600, 16'h8200, 16);
    pulse();
    wait_idle("cancel_block", 300, n);
    check_drained("cancel_block");
    check_ff55("cancel_before", 8'h02);
    reg_wr(16'hFF55, 8'h00);
    check_ff55("cancel_after", 8'h82);
    base = wr_count;
    pulse();
    repeat (20) @(negedge clk);
    total++;
    if (active !== 1'b0 || wr_count != base) begin
      bad++;
      $display("FAIL cancel_no_block active=%b writes=%0d want 0 0", active, wr_count - base);
    end
  endtask

  task automatic test_arbitration();
    int n;
    set_hdma(8'hC7, 8'h00, 8'h03, 8'h00);
    reg_wr(16'hFF55, 8'h80);
    push_run(16'hC000, 16'hFE00, 160);
    push_run(16'hC700, 16'h8300, 16);
    reg_wr(16'hFF46, 8'hC0);
    n = 0;
    while (active && n < 2000) begin
      n++;
      hblank_start = (n == 100);
      @(negedge clk);
    end
    hblank_start = 1'b0;
    total++;
    if (n != 704) begin bad++; $display("FAIL arb_cycles got=%0d want=704", n); end
    check_drained("arb");
    check_ff55("arb_done", 8'hFF);
  endtask

  task automatic test_dst_end();
    int n;
    set_hdma(8'hC8, 8'h00, 8'h1F, 8'hF0);
    push_run(16'hC800, 16'h9FF0, 16);
    reg_wr(16'hFF55, 8'h01);
    n = 0;
    while (cpu_halt && n < 500) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 64) begin bad++; $display("FAIL dst_end_halt_cycles got=%0d want=64", n); end
    check_drained("dst_end");
    check_ff55("dst_end", 8'hFF);
  endtask
`endif

  initial begin
    bus.reg_addr = 16'h0000;
    bus.reg_wdata = 8'h00;
    bus.reg_write_en = 1'b0;
    bus.reg_read_en = 1'b0;
    bus.mem_rdata = 8'h00;
    test_reset();
    test_open_bus();
    test_oam_basic();
    test_oam_restart();
    test_reset_abort();
`ifdef DMA_HDMA_EN
    test_gdma();
    test_hblank();
    test_cancel();
    test_arbitration();
    test_dst_end();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
